// File: rtl/otp_keystream_arbiter.sv
// Shares one 64-bit LFSR keystream between two requesters and applies out = ~data ^ ks per block.
// Handles seeding, round-robin grant, output handshake and lockout after MAX_BLOCKS words.
module otp_keystream_arbiter #(
    parameter int unsigned MAX_BLOCKS   = 1024,
    parameter logic [63:0] DEFAULT_SEED = 64'h0000_0000_0000_0001
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        seed_valid,
    input  logic [63:0] seed,
    output logic        seed_ready,
    input  logic        req0_valid,
    input  logic [63:0] req0_data,
    output logic        req0_ready,
    input  logic        req1_valid,
    input  logic [63:0] req1_data,
    output logic        req1_ready,
    output logic        out_valid,
    output logic [63:0] out_data,
    output logic        out_id,
    input  logic        out_ready,
    output logic [15:0] blk_count,
    output logic        exhausted,
    output logic [1:0]  dbg_state
);

    // Handshakes: a transfer happens on a rising edge where valid & ready are both high.
    // reqN_ready is a grant and only rises with reqN_valid; out_data/out_id hold while out_valid & !out_ready.

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_RUN       = 2'd1,
        ST_EXHAUSTED = 2'd2
    } state_t;

    localparam logic [15:0] MAX_CNT = 16'(MAX_BLOCKS);

    state_t      state_q, state_d;
    logic [63:0] ks_q, ks_d;
    logic [15:0] blk_count_q, blk_count_d;
    logic        rr_ptr_q, rr_ptr_d;
    logic        out_valid_q, out_valid_d;
    logic [63:0] out_data_q, out_data_d;
    logic        out_id_q, out_id_d;

    logic        can_accept;
    logic        grant0;
    logic        grant1;
    logic        seed_load;
    logic [63:0] ks_next;
    logic [15:0] blk_count_inc;

    assign ks_next       = {ks_q[62:0], ks_q[63] ^ ks_q[62] ^ ks_q[60] ^ ks_q[59]};
    assign blk_count_inc = blk_count_q + 16'd1;

    // A new grant is allowed only when the output register is empty or draining this cycle.
    assign can_accept = (state_q == ST_RUN) && (!out_valid_q || out_ready);
    assign grant0     = can_accept && req0_valid && (!req1_valid || !rr_ptr_q);
    assign grant1     = can_accept && req1_valid && (!req0_valid || rr_ptr_q);
    assign seed_load  = seed_valid && (state_q != ST_RUN);

    always_comb begin
        state_d     = state_q;
        ks_d        = ks_q;
        blk_count_d = blk_count_q;
        rr_ptr_d    = rr_ptr_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_id_d    = out_id_q;

        if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end

        // Seeding never touches a pending result; it only restarts the keystream.
        if (seed_load) begin
            ks_d        = (seed == 64'd0) ? DEFAULT_SEED : seed;
            blk_count_d = 16'd0;
            rr_ptr_d    = 1'b0;
            state_d     = ST_RUN;
        end

        if (grant0 || grant1) begin
            out_data_d  = ~(grant1 ? req1_data : req0_data) ^ ks_q;
            out_id_d    = grant1;
            out_valid_d = 1'b1;
            ks_d        = ks_next;
            blk_count_d = blk_count_inc;
            rr_ptr_d    = ~grant1;
            if (blk_count_inc == MAX_CNT) begin
                state_d = ST_EXHAUSTED;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            ks_q        <= 64'd0;
            blk_count_q <= 16'd0;
            rr_ptr_q    <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= 64'd0;
            out_id_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            ks_q        <= ks_d;
            blk_count_q <= blk_count_d;
            rr_ptr_q    <= rr_ptr_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_id_q    <= out_id_d;
        end
    end

    assign seed_ready = (state_q != ST_RUN);
    assign req0_ready = grant0;
    assign req1_ready = grant1;
    assign out_valid  = out_valid_q;
    assign out_data   = out_data_q;
    assign out_id     = out_id_q;
    assign blk_count  = blk_count_q;
    assign exhausted  = (state_q == ST_EXHAUSTED);
    assign dbg_state  = state_q;

endmodule
